// File: rtl/ram_resp.sv
// ram_resp: data-RAM responder at the memory end of the scalar core's RAM port.
// It serves 64-bit reads and bit-masked writes from an internal DEPTH x 64 word
// array. The read path is registered, and a write issued in the same cycle is
// forwarded to the read. After reset the whole array is zero-filled. Every
// access is range checked against BASE, and accepted accesses are counted.
//
// Ports:
//   clk            clock; all state updates on the rising edge
//   rst            synchronous active-high reset
//   ram_r_ena_i    read request this cycle
//   ram_r_addr_i   read byte address (bits [2:0] ignored)
//   ram_r_data_o   read data, valid while ram_r_valid_o is high, held otherwise
//   ram_r_valid_o  one-cycle pulse, one cycle after an accepted read
//   ram_w_ena_i    write request this cycle
//   ram_w_addr_i   write byte address (bits [2:0] ignored)
//   ram_w_data_i   write data
//   ram_w_mask_i   per-bit write enable, 1 = bit is written
//   ram_busy_o     high while zero-filling; requests are ignored
//   ram_err_o      one-cycle pulse, one cycle after an out-of-range access
//   rd_cnt_o       accepted in-range reads, wraps modulo 2^32
//   wr_cnt_o       accepted in-range writes, wraps modulo 2^32

module ram_resp #(
    parameter int          DEPTH = 512,
    parameter logic [63:0] BASE  = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_r_ena_i,
    input  logic [63:0] ram_r_addr_i,
    output logic [63:0] ram_r_data_o,
    output logic        ram_r_valid_o,
    input  logic        ram_w_ena_i,
    input  logic [63:0] ram_w_addr_i,
    input  logic [63:0] ram_w_data_i,
    input  logic [63:0] ram_w_mask_i,
    output logic        ram_busy_o,
    output logic        ram_err_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o
);

    localparam int          IDXW  = $clog2(DEPTH);
    localparam logic [63:0] SPAN  = 64'(DEPTH) * 64'd8;
    localparam logic [63:0] LIMIT = BASE + SPAN;
    localparam logic [IDXW-1:0] LAST = IDXW'(DEPTH - 1);

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

    state_t            state;
    logic [IDXW-1:0]   ptr;
    logic [63:0]       mem [DEPTH];

    logic [IDXW-1:0]   r_idx;
    logic [IDXW-1:0]   w_idx;
    logic              r_in_range;
    logic              w_in_range;
    logic              rd_take;
    logic              wr_take;
    logic              rd_bad;
    logic              wr_bad;
    logic [63:0]       w_merged;
    logic [63:0]       r_word;
    logic              valid_q;

    // Decode both ports, qualify them with the FSM state and build the merged
    // write word. The read word takes the merged value when the write hits
    // the same index in this cycle, which gives write-first behaviour.
    always_comb begin
        r_idx      = ram_r_addr_i[3 +: IDXW];
        w_idx      = ram_w_addr_i[3 +: IDXW];
        r_in_range = (ram_r_addr_i >= BASE) && (ram_r_addr_i < LIMIT);
        w_in_range = (ram_w_addr_i >= BASE) && (ram_w_addr_i < LIMIT);
        rd_take    = (state == READY) && ram_r_ena_i && r_in_range;
        wr_take    = (state == READY) && ram_w_ena_i && w_in_range;
        rd_bad     = (state == READY) && ram_r_ena_i && !r_in_range;
        wr_bad     = (state == READY) && ram_w_ena_i && !w_in_range;
        w_merged   = (mem[w_idx] & ~ram_w_mask_i) | (ram_w_data_i & ram_w_mask_i);
        r_word     = mem[r_idx];
        if (wr_take && (w_idx == r_idx)) begin
            r_word = (r_word & ~ram_w_mask_i) | (ram_w_data_i & ram_w_mask_i);
        end
    end

    // Control FSM, read response and counters. In CLEAR the fill pointer walks
    // the array once. READY is then held until reset. An out-of-range read
    // still returns a valid pulse, with zero data.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= CLEAR;
            ptr          <= '0;
            valid_q      <= 1'b0;
            ram_r_data_o <= '0;
            ram_err_o    <= 1'b0;
            rd_cnt_o     <= '0;
            wr_cnt_o     <= '0;
        end else begin
            valid_q   <= 1'b0;
            ram_err_o <= 1'b0;
            case (state)
                CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == LAST) begin
                        state <= READY;
                    end
                end
                READY: begin
                    if (ram_r_ena_i) begin
                        valid_q      <= 1'b1;
                        ram_r_data_o <= r_in_range ? r_word : 64'd0;
                    end
                    ram_err_o <= rd_bad || wr_bad;
                    if (rd_take) begin
                        rd_cnt_o <= rd_cnt_o + 32'd1;
                    end
                    if (wr_take) begin
                        wr_cnt_o <= wr_cnt_o + 32'd1;
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Single write port on the array. The zero-fill has priority by state, and
    // nothing is written in a reset cycle, so a write issued alongside reset
    // is dropped.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[ptr] <= '0;
            end else if (wr_take) begin
                mem[w_idx] <= w_merged;
            end
        end
    end

    // A read accepted just before reset must not surface as a valid pulse
    // during the reset cycle, so the registered pulse is masked by rst.
    assign ram_r_valid_o = valid_q && !rst;
    assign ram_busy_o    = (state == CLEAR);

endmodule

// File: tb/tb_ram_resp.sv
// tb_ram_resp: directed self-checking bench for ram_resp.
// Inputs are driven on the falling edge. Outputs are sampled on the falling
// edge that follows the rising edge which updated them.

module tb_ram_resp;

    localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;
    localparam int          DEPTH = 512;

    logic        clk;
    logic        rst;
    logic        ram_r_ena_i;
    logic [63:0] ram_r_addr_i;
    logic [63:0] ram_r_data_o;
    logic        ram_r_valid_o;
    logic        ram_w_ena_i;
    logic [63:0] ram_w_addr_i;
    logic [63:0] ram_w_data_i;
    logic [63:0] ram_w_mask_i;
    logic        ram_busy_o;
    logic        ram_err_o;
    logic [31:0] rd_cnt_o;
    logic [31:0] wr_cnt_o;

    int pass_count;
    int check_count;

    ram_resp #(.DEPTH(DEPTH), .BASE(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .ram_r_ena_i   (ram_r_ena_i),
        .ram_r_addr_i  (ram_r_addr_i),
        .ram_r_data_o  (ram_r_data_o),
        .ram_r_valid_o (ram_r_valid_o),
        .ram_w_ena_i   (ram_w_ena_i),
        .ram_w_addr_i  (ram_w_addr_i),
        .ram_w_data_i  (ram_w_data_i),
        .ram_w_mask_i  (ram_w_mask_i),
        .ram_busy_o    (ram_busy_o),
        .ram_err_o     (ram_err_o),
        .rd_cnt_o      (rd_cnt_o),
        .wr_cnt_o      (wr_cnt_o)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drop all request lines.
    task automatic idle();
        ram_r_ena_i  = 1'b0;
        ram_r_addr_i = '0;
        ram_w_ena_i  = 1'b0;
        ram_w_addr_i = '0;
        ram_w_data_i = '0;
        ram_w_mask_i = '0;
    endtask

    // Reset values while rst is held high.
    task automatic test_reset();
        rst = 1'b1;
        idle();
        repeat (2) @(negedge clk);
        check_count++;
        if (ram_r_valid_o !== 1'b0) $display("[TB] FAIL reset_valid got=%0b exp=0", ram_r_valid_o);
        else pass_count++;
        check_count++;
        if (ram_r_data_o !== 64'd0) $display("[TB] FAIL reset_data got=%h exp=0", ram_r_data_o);
        else pass_count++;
        check_count++;
        if (ram_err_o !== 1'b0) $display("[TB] FAIL reset_err got=%0b exp=0", ram_err_o);
        else pass_count++;
        check_count++;
        if (ram_busy_o !== 1'b1) $display("[TB] FAIL reset_busy got=%0b exp=1", ram_busy_o);
        else pass_count++;
        check_count++;
        if (rd_cnt_o !== 32'd0 || wr_cnt_o !== 32'd0)
            $display("[TB] FAIL reset_counts got=%0d/%0d exp=0/0", rd_cnt_o, wr_cnt_o);
        else pass_count++;
    endtask

    // Release reset while reading every cycle. Busy must last exactly DEPTH
    // cycles. The first READY read then returns zero with rd_cnt = 1.
    task automatic test_fill();
        int busy_cycles;
        int stray;
        busy_cycles = 0;
        stray = 0;
        rst = 1'b0;
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = BASE + 64'h40;
        while (ram_busy_o === 1'b1 && busy_cycles < 2000) begin
            if (ram_r_valid_o !== 1'b0 || ram_err_o !== 1'b0) stray++;
            busy_cycles++;
            @(negedge clk);
        end
        check_count++;
        if (busy_cycles !== DEPTH) $display("[TB] FAIL fill_busy_cycles got=%0d exp=%0d", busy_cycles, DEPTH);
        else pass_count++;
        check_count++;
        if (stray !== 0 || ram_r_valid_o !== 1'b0 || rd_cnt_o !== 32'd0)
            $display("[TB] FAIL fill_ignored got stray=%0d valid=%0b rd_cnt=%0d exp=0/0/0", stray, ram_r_valid_o, rd_cnt_o);
        else pass_count++;
        @(negedge clk);
        ram_r_ena_i = 1'b0;
        check_count++;
        if (ram_r_valid_o !== 1'b1 || ram_r_data_o !== 64'd0)
            $display("[TB] FAIL fill_first_read got valid=%0b data=%h exp=1/0", ram_r_valid_o, ram_r_data_o);
        else pass_count++;
        check_count++;
        if (rd_cnt_o !== 32'd1) $display("[TB] FAIL fill_rd_cnt got=%0d exp=1", rd_cnt_o);
        else pass_count++;
        @(negedge clk);
        check_count++;
        if (ram_r_valid_o !== 1'b0) $display("[TB] FAIL fill_valid_pulse got=%0b exp=0", ram_r_valid_o);
        else pass_count++;
    endtask

    // Two writes to word 2: a full write, then an upper-half masked write.
    task automatic test_masked_write();
        ram_w_ena_i  = 1'b1;
        ram_w_addr_i = 64'h8000_0010;
        ram_w_data_i = 64'h1122_3344_5566_7788;
        ram_w_mask_i = '1;
        @(negedge clk);
        ram_w_addr_i = 64'h8000_0014;
        ram_w_data_i = 64'hAAAA_AAAA_0000_0000;
        ram_w_mask_i = 64'hFFFF_FFFF_0000_0000;
        @(negedge clk);
        idle();
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = 64'h8000_0010;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_valid_o !== 1'b1 || ram_r_data_o !== 64'hAAAA_AAAA_5566_7788)
            $display("[TB] FAIL masked_data got valid=%0b data=%h exp=1/aaaaaaaa55667788", ram_r_valid_o, ram_r_data_o);
        else pass_count++;
        check_count++;
        if (wr_cnt_o !== 32'd2 || rd_cnt_o !== 32'd2 || ram_err_o !== 1'b0)
            $display("[TB] FAIL masked_counts got wr=%0d rd=%0d err=%0b exp=2/2/0", wr_cnt_o, rd_cnt_o, ram_err_o);
        else pass_count++;
    endtask

    // Read and masked write to the same zeroed word in one cycle.
    task automatic test_forwarding();
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = 64'h8000_0020;
        ram_w_ena_i  = 1'b1;
        ram_w_addr_i = 64'h8000_0020;
        ram_w_data_i = 64'hFF;
        ram_w_mask_i = 64'h0F;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_valid_o !== 1'b1 || ram_r_data_o !== 64'h0F)
            $display("[TB] FAIL fwd_data got valid=%0b data=%h exp=1/0f", ram_r_valid_o, ram_r_data_o);
        else pass_count++;
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = 64'h8000_0020;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_data_o !== 64'h0F || rd_cnt_o !== 32'd4 || wr_cnt_o !== 32'd3)
            $display("[TB] FAIL fwd_persist got data=%h rd=%0d wr=%0d exp=0f/4/3", ram_r_data_o, rd_cnt_o, wr_cnt_o);
        else pass_count++;
    endtask

    // Out-of-range read above the window and write below it in one cycle.
    task automatic test_out_of_range();
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = 64'h8000_1000;
        ram_w_ena_i  = 1'b1;
        ram_w_addr_i = 64'h7FFF_FFF8;
        ram_w_data_i = 64'hDEAD_BEEF_CAFE_F00D;
        ram_w_mask_i = '1;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_valid_o !== 1'b1 || ram_r_data_o !== 64'd0 || ram_err_o !== 1'b1)
            $display("[TB] FAIL oor_resp got valid=%0b data=%h err=%0b exp=1/0/1", ram_r_valid_o, ram_r_data_o, ram_err_o);
        else pass_count++;
        check_count++;
        if (rd_cnt_o !== 32'd4 || wr_cnt_o !== 32'd3)
            $display("[TB] FAIL oor_counts got rd=%0d wr=%0d exp=4/3", rd_cnt_o, wr_cnt_o);
        else pass_count++;
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = 64'h8000_0FF8;
        @(negedge clk);
        check_count++;
        if (ram_err_o !== 1'b0) $display("[TB] FAIL oor_err_single got=%0b exp=0", ram_err_o);
        else pass_count++;
        check_count++;
        if (ram_r_valid_o !== 1'b1 || ram_r_data_o !== 64'd0)
            $display("[TB] FAIL oor_word511 got valid=%0b data=%h exp=1/0", ram_r_valid_o, ram_r_data_o);
        else pass_count++;
        ram_r_addr_i = 64'h8000_0000;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_data_o !== 64'd0 || rd_cnt_o !== 32'd6)
            $display("[TB] FAIL oor_word0 got data=%h rd=%0d exp=0/6", ram_r_data_o, rd_cnt_o);
        else pass_count++;
    endtask

    // Fill words 1 and 3, then read 1, 2, 3 on consecutive cycles while also
    // writing word 5, then read word 5 back.
    task automatic test_back_to_back();
        logic [63:0] exp_data [3];
        exp_data[0] = 64'h1111_0000_0000_1111;
        exp_data[1] = 64'hAAAA_AAAA_5566_7788;
        exp_data[2] = 64'h3333_0000_0000_3333;
        ram_w_ena_i  = 1'b1;
        ram_w_mask_i = '1;
        ram_w_addr_i = BASE + 64'h08;
        ram_w_data_i = exp_data[0];
        @(negedge clk);
        ram_w_addr_i = BASE + 64'h18;
        ram_w_data_i = exp_data[2];
        @(negedge clk);
        ram_w_addr_i = BASE + 64'h28;
        ram_w_data_i = 64'h5555_5555_5555_5555;
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = BASE + 64'h08;
        @(negedge clk);
        ram_w_ena_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (i < 2) ram_r_addr_i = BASE + 64'(8 * (i + 2));
            else ram_r_ena_i = 1'b0;
            check_count++;
            if (ram_r_valid_o !== 1'b1 || ram_r_data_o !== exp_data[i])
                $display("[TB] FAIL b2b_read%0d got valid=%0b data=%h exp=1/%h", i + 1, ram_r_valid_o, ram_r_data_o, exp_data[i]);
            else pass_count++;
            @(negedge clk);
        end
        check_count++;
        if (ram_r_valid_o !== 1'b0) $display("[TB] FAIL b2b_end_valid got=%0b exp=0", ram_r_valid_o);
        else pass_count++;
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = BASE + 64'h28;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_data_o !== 64'h5555_5555_5555_5555 || rd_cnt_o !== 32'd10 || wr_cnt_o !== 32'd6)
            $display("[TB] FAIL b2b_word5 got data=%h rd=%0d wr=%0d exp=5555555555555555/10/6", ram_r_data_o, rd_cnt_o, wr_cnt_o);
        else pass_count++;
    endtask

    // Read, then reset on the next cycle. No valid pulse may appear, and the
    // refill must clear the array from index 0 again.
    task automatic test_reset_midstream();
        int busy_cycles;
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = BASE + 64'h08;
        @(negedge clk);
        idle();
        rst = 1'b1;
        ram_w_ena_i  = 1'b1;
        ram_w_addr_i = BASE + 64'h30;
        ram_w_data_i = '1;
        ram_w_mask_i = '1;
        #1;
        check_count++;
        if (ram_r_valid_o !== 1'b0) $display("[TB] FAIL mid_no_valid got=%0b exp=0", ram_r_valid_o);
        else pass_count++;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_valid_o !== 1'b0 || ram_busy_o !== 1'b1 || rd_cnt_o !== 32'd0 || wr_cnt_o !== 32'd0)
            $display("[TB] FAIL mid_reset_state got valid=%0b busy=%0b rd=%0d wr=%0d exp=0/1/0/0", ram_r_valid_o, ram_busy_o, rd_cnt_o, wr_cnt_o);
        else pass_count++;
        rst = 1'b0;
        busy_cycles = 0;
        while (ram_busy_o === 1'b1 && busy_cycles < 2000) begin
            busy_cycles++;
            @(negedge clk);
        end
        check_count++;
        if (busy_cycles !== DEPTH) $display("[TB] FAIL mid_refill_cycles got=%0d exp=%0d", busy_cycles, DEPTH);
        else pass_count++;
        ram_r_ena_i  = 1'b1;
        ram_r_addr_i = BASE + 64'h08;
        @(negedge clk);
        ram_r_addr_i = BASE + 64'h30;
        check_count++;
        if (ram_r_valid_o !== 1'b1 || ram_r_data_o !== 64'd0)
            $display("[TB] FAIL mid_word1_cleared got valid=%0b data=%h exp=1/0", ram_r_valid_o, ram_r_data_o);
        else pass_count++;
        @(negedge clk);
        idle();
        check_count++;
        if (ram_r_data_o !== 64'd0 || rd_cnt_o !== 32'd2)
            $display("[TB] FAIL mid_word6_dropped got data=%h rd=%0d exp=0/2", ram_r_data_o, rd_cnt_o);
        else pass_count++;
    endtask

    initial begin
        pass_count  = 0;
        check_count = 0;
        test_reset();
        test_fill();
        test_masked_write();
        test_forwarding();
        test_out_of_range();
        test_back_to_back();
        test_reset_midstream();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
